spi_xfer_ctrl: RTL and testbench

SPI_XFER_CTRL -- requirements
Module: spi_xfer_ctrl

---
 rtl/spi_xfer_ctrl.sv | 204 ++++++++++++++++++++
 tb/tb_spi_xfer_ctrl.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_xfer_ctrl.sv
// Transfer sequencer for a single-word SPI master: TX/RX word FIFOs, config
// forwarding when the pipe is empty, and a per-transfer watchdog.
//
// state  | meaning
// IDLE   | waiting for a config request or a queued TX word with RX room
// CONFIG | config_req pulse, latched config word presented to the master
// START  | spi_start pulse, din holds the word just popped from TX
// WAIT   | transfer in flight, watchdog counting until spi_finish or timeout

module spi_xfer_ctrl #(
    parameter int SPI_MAX_WIDTH_LOG = 4,
    parameter int FIFO_DEPTH_LOG    = 2,
    parameter int TIMEOUT_LOG       = 12
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            cfg_valid,
    output logic                            cfg_ready,
    input  logic [SPI_MAX_WIDTH_LOG+1:0]    cfg_data,
    input  logic                            tx_valid,
    output logic                            tx_ready,
    input  logic [2**SPI_MAX_WIDTH_LOG-1:0] tx_data,
    output logic                            rx_valid,
    input  logic                            rx_ready,
    output logic [2**SPI_MAX_WIDTH_LOG-1:0] rx_data,
    output logic                            config_req,
    output logic [SPI_MAX_WIDTH_LOG+1:0]    config_data,
    output logic                            spi_start,
    output logic [2**SPI_MAX_WIDTH_LOG-1:0] din,
    input  logic                            spi_finish,
    input  logic [2**SPI_MAX_WIDTH_LOG-1:0] dout,
    output logic                            busy,
    output logic                            err,
    input  logic                            err_clr
);

    localparam int W  = 2**SPI_MAX_WIDTH_LOG;
    localparam int D  = 2**FIFO_DEPTH_LOG;
    localparam int PW = FIFO_DEPTH_LOG;
    localparam int CW = FIFO_DEPTH_LOG + 1;
    localparam logic [CW-1:0]          DEPTH     = CW'(D);
    localparam logic [TIMEOUT_LOG-1:0] WDOG_LAST = '1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CONFIG = 2'd1,
        START  = 2'd2,
        WAIT   = 2'd3
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [W-1:0]           tx_mem [D];
    logic [W-1:0]           rx_mem [D];
    logic [PW-1:0]          tx_wr_ptr;
    logic [PW-1:0]          tx_rd_ptr;
    logic [PW-1:0]          rx_wr_ptr;
    logic [PW-1:0]          rx_rd_ptr;
    logic [CW-1:0]          tx_count;
    logic [CW-1:0]          rx_count;
    logic [TIMEOUT_LOG-1:0] wdog;

    logic cfg_fire;
    logic launch;
    logic timeout;
    logic tx_push;
    logic tx_pop;
    logic rx_push;
    logic rx_pop;

    assign tx_ready  = (tx_count < DEPTH);
    assign rx_valid  = (rx_count != '0);
    assign rx_data   = rx_mem[rx_rd_ptr];
    assign cfg_ready = (state == IDLE) && (tx_count == '0);
    assign busy      = (state != IDLE) || (tx_count != '0);

    assign cfg_fire = cfg_valid && cfg_ready;
    // Launch only with RX room, so a finishing transfer can always be pushed.
    assign launch   = (state == IDLE) && !cfg_fire && (tx_count != '0) && (rx_count < DEPTH);
    assign timeout  = (state == WAIT) && !spi_finish && (wdog == WDOG_LAST);

    assign tx_push = tx_valid && tx_ready;
    assign tx_pop  = launch;
    assign rx_push = (state == WAIT) && spi_finish;
    assign rx_pop  = rx_valid && rx_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        config_req = 1'b0;
        spi_start  = 1'b0;
        case (state)
            IDLE: begin
                if (cfg_fire) begin
                    state_nxt = CONFIG;
                end else if (launch) begin
                    state_nxt = START;
                end
            end
            CONFIG: begin
                config_req = 1'b1;
                state_nxt  = IDLE;
            end
            START: begin
                spi_start = 1'b1;
                state_nxt = WAIT;
            end
            WAIT: begin
                if (spi_finish || timeout) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tx_wr_ptr <= '0;
            tx_rd_ptr <= '0;
            tx_count  <= '0;
        end else begin
            if (tx_push) begin
                tx_wr_ptr <= tx_wr_ptr + PW'(1);
            end
            if (tx_pop) begin
                tx_rd_ptr <= tx_rd_ptr + PW'(1);
            end
            case ({tx_push, tx_pop})
                2'b10:   tx_count <= tx_count + CW'(1);
                2'b01:   tx_count <= tx_count - CW'(1);
                default: tx_count <= tx_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (tx_push) begin
            tx_mem[tx_wr_ptr] <= tx_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_wr_ptr <= '0;
            rx_rd_ptr <= '0;
            rx_count  <= '0;
        end else begin
            if (rx_push) begin
                rx_wr_ptr <= rx_wr_ptr + PW'(1);
            end
            if (rx_pop) begin
                rx_rd_ptr <= rx_rd_ptr + PW'(1);
            end
            case ({rx_push, rx_pop})
                2'b10:   rx_count <= rx_count + CW'(1);
                2'b01:   rx_count <= rx_count - CW'(1);
                default: rx_count <= rx_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rx_push) begin
            rx_mem[rx_wr_ptr] <= dout;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            config_data <= '0;
            din         <= '0;
            wdog        <= '0;
            err         <= 1'b0;
        end else begin
            if (cfg_fire) begin
                config_data <= cfg_data;
            end
            if (launch) begin
                din <= tx_mem[tx_rd_ptr];
            end
            if (state == START) begin
                wdog <= '0;
            end else if (state == WAIT) begin
                wdog <= wdog + TIMEOUT_LOG'(1);
            end
            // A timeout in the same cycle as err_clr must still be reported.
            if (timeout) begin
                err <= 1'b1;
            end else if (err_clr) begin
                err <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_spi_xfer_ctrl.sv
// Bench for spi_xfer_ctrl: a slave model echoes ~din, and queues of the words
// pushed and the replies expected predict din order and rx_data.

module tb_spi_xfer_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    always #5 clk = ~clk;

    logic        cfg_valid, cfg_ready, tx_valid, tx_ready, rx_valid, rx_ready;
    logic        config_req, spi_start, spi_finish, busy, err, err_clr;
    logic [5:0]  cfg_data, config_data;
    logic [15:0] tx_data, rx_data, din, dout;

    logic        b_cfg_valid, b_cfg_ready, b_tx_valid, b_tx_ready, b_rx_valid, b_rx_ready;
    logic        b_config_req, b_spi_start, b_spi_finish, b_busy, b_err, b_err_clr;
    logic [5:0]  b_cfg_data, b_config_data;
    logic [15:0] b_tx_data, b_rx_data, b_din, b_dout;

    spi_xfer_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_data(cfg_data),
        .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_data(tx_data),
        .rx_valid(rx_valid), .rx_ready(rx_ready), .rx_data(rx_data),
        .config_req(config_req), .config_data(config_data),
        .spi_start(spi_start), .din(din), .spi_finish(spi_finish), .dout(dout),
        .busy(busy), .err(err), .err_clr(err_clr)
    );

    spi_xfer_ctrl #(.TIMEOUT_LOG(4)) dut_to (
        .clk(clk), .rst_n(rst_n),
        .cfg_valid(b_cfg_valid), .cfg_ready(b_cfg_ready), .cfg_data(b_cfg_data),
        .tx_valid(b_tx_valid), .tx_ready(b_tx_ready), .tx_data(b_tx_data),
        .rx_valid(b_rx_valid), .rx_ready(b_rx_ready), .rx_data(b_rx_data),
        .config_req(b_config_req), .config_data(b_config_data),
        .spi_start(b_spi_start), .din(b_din), .spi_finish(b_spi_finish), .dout(b_dout),
        .busy(b_busy), .err(b_err), .err_clr(b_err_clr)
    );

    int          n_pass  = 0;
    int          n_total = 0;
    int          n_starts = 0;
    int          n_done   = 0;
    logic [15:0] start_din [$];
    logic [15:0] tx_q [$];
    logic [15:0] rx_q [$];
    logic [5:0]  cfg_v;
    logic [15:0] v;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Records every transfer launch and the word presented on din.
    initial forever begin
        @(posedge clk);
        #2;
        if (spi_start === 1'b1) begin
            n_starts++;
            start_din.push_back(din);
        end
    end

    task automatic push_tx(input logic [15:0] w);
        chk("tx_ready_before_push", tx_ready, 1);
        tx_valid = 1'b1;
        tx_data  = w;
        tx_q.push_back(w);
        @(negedge clk);
        tx_valid = 1'b0;
    endtask

    task automatic rx_pop();
        chk("rx_valid_pop", rx_valid, 1);
        chk("rx_data_pop", rx_data, rx_q.pop_front());
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
    endtask

    // Slave side of one transfer: wait for a launch, check its word, answer ~word.
    task automatic do_xfer(input int dly, input bit pop_too);
        int          g = 0;
        logic [15:0] exp_w;
        logic [15:0] seen;
        while (n_starts <= n_done && g < 300) begin
            @(negedge clk);
            g++;
        end
        chk("xfer_started", 32'(n_starts > n_done), 1);
        if (n_starts > n_done) begin
            seen  = start_din[n_done];
            exp_w = tx_q.pop_front();
            chk("din_order", seen, exp_w);
            repeat (dly) @(negedge clk);
            if (pop_too) begin
                chk("rx_valid_simul", rx_valid, 1);
                chk("rx_data_simul", rx_data, rx_q.pop_front());
                rx_ready = 1'b1;
            end
            spi_finish = 1'b1;
            dout       = ~seen;
            rx_q.push_back(~exp_w);
            @(negedge clk);
            spi_finish = 1'b0;
            rx_ready   = 1'b0;
            n_done++;
        end
    endtask

    task automatic b_push();
        b_tx_valid = 1'b1;
        b_tx_data  = 16'($urandom);
        @(negedge clk);
        b_tx_valid = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: observed running expected finished");
        $fatal(1, "bench time limit");
    end

    initial begin
        int g;
        rst_n = 1'b0;
        cfg_valid = 0; cfg_data = 0; tx_valid = 0; tx_data = 0; rx_ready = 0;
        spi_finish = 0; dout = 0; err_clr = 0;
        b_cfg_valid = 0; b_cfg_data = 0; b_tx_valid = 0; b_tx_data = 0; b_rx_ready = 0;
        b_spi_finish = 0; b_dout = 0; b_err_clr = 0;
        repeat (3) @(negedge clk);

        chk("rst_config_req", config_req, 0);
        chk("rst_config_data", config_data, 0);
        chk("rst_spi_start", spi_start, 0);
        chk("rst_din", din, 0);
        chk("rst_rx_valid", rx_valid, 0);
        chk("rst_tx_ready", tx_ready, 1);
        chk("rst_cfg_ready", cfg_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_err", err, 0);
        chk("b_rst_outputs", {b_config_req, b_spi_start, b_rx_valid, b_busy, b_err,
                              b_tx_ready, b_cfg_ready}, 7'b0000011);
        chk("b_rst_regs", {b_config_data, b_din}, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Config then a single word with a 40-cycle slave reply.
        cfg_valid = 1'b1;
        cfg_data  = 6'h2F;
        @(negedge clk);
        cfg_valid = 1'b0;
        chk("cfg_req_on", config_req, 1);
        chk("cfg_data_latched", config_data, 6'h2F);
        chk("cfg_ready_in_config", cfg_ready, 0);
        @(negedge clk);
        chk("cfg_req_one_cycle", config_req, 0);
        tx_valid = 1'b1;
        tx_data  = 16'hA55A;
        @(negedge clk);
        tx_valid = 1'b0;
        chk("start_at_n1", spi_start, 0);
        chk("busy_queued", busy, 1);
        @(negedge clk);
        chk("start_at_n2", spi_start, 1);
        chk("din_first", din, 16'hA55A);
        @(negedge clk);
        chk("start_one_cycle", spi_start, 0);
        repeat (38) @(negedge clk);
        chk("rx_empty_before_finish", rx_valid, 0);
        spi_finish = 1'b1;
        dout       = 16'h5AA5;
        @(negedge clk);
        spi_finish = 1'b0;
        chk("rx_valid_after_finish", rx_valid, 1);
        chk("rx_data_echo", rx_data, 16'h5AA5);
        chk("idle_after_finish", busy, 0);
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
        chk("rx_drained", rx_valid, 0);
        n_done = 1;
        chk("one_start_so_far", n_starts, 1);

        // Back-pressure: RX held full, then simultaneous push/pop on both FIFOs.
        repeat (4) push_tx(16'($urandom));
        repeat (4) do_xfer(int'($urandom_range(1, 6)), 1'b0);
        repeat (3) @(negedge clk);
        chk("four_xfers", n_starts, 5);
        chk("rx_full_valid", rx_valid, 1);
        repeat (3) push_tx(16'($urandom));
        repeat (10) @(negedge clk);
        chk("start_held_rx_full", n_starts, 5);
        chk("busy_held", busy, 1);
        rx_pop();
        push_tx(16'($urandom));
        chk("tx_ready_simul_push_pop", tx_ready, 1);
        push_tx(16'($urandom));
        chk("tx_ready_full", tx_ready, 0);
        do_xfer(int'($urandom_range(1, 6)), 1'b1);
        repeat (4) do_xfer(int'($urandom_range(1, 6)), 1'b1);
        while (rx_q.size() > 0) rx_pop();
        chk("rx_empty_end_bp", rx_valid, 0);
        chk("idle_end_bp", busy, 0);
        chk("total_starts_bp", n_starts, 10);

        // Config blocked while words are queued or in flight.
        push_tx(16'($urandom));
        push_tx(16'($urandom));
        cfg_v     = 6'($urandom);
        cfg_valid = 1'b1;
        cfg_data  = cfg_v;
        @(negedge clk);
        chk("cfg_blocked", cfg_ready, 0);
        chk("cfg_req_blocked", config_req, 0);
        do_xfer(int'($urandom_range(1, 6)), 1'b0);
        chk("cfg_blocked_mid", cfg_ready, 0);
        do_xfer(int'($urandom_range(1, 6)), 1'b0);
        g = 0;
        while (config_req !== 1'b1 && g < 5) begin
            @(negedge clk);
            g++;
        end
        chk("cfg_req_after_drain", config_req, 1);
        chk("cfg_data_after_drain", config_data, cfg_v);
        cfg_valid = 1'b0;
        @(negedge clk);
        chk("cfg_req_pulse_end", config_req, 0);
        rx_pop();
        rx_pop();

        // spi_finish outside WAIT must not push.
        spi_finish = 1'b1;
        dout       = 16'($urandom);
        @(negedge clk);
        spi_finish = 1'b0;
        @(negedge clk);
        chk("stray_finish_no_push", rx_valid, 0);

        // Reset in WAIT abandons the transfer and queued word.
        push_tx(16'($urandom));
        push_tx(16'($urandom));
        g = 0;
        while (n_starts <= n_done && g < 20) begin
            @(negedge clk);
            g++;
        end
        chk("reset_case_started", n_starts, n_done + 1);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        spi_finish = 1'b1;
        dout       = 16'($urandom);
        @(negedge clk);
        spi_finish = 1'b0;
        @(negedge clk);
        chk("rst_wait_rx_valid", rx_valid, 0);
        chk("rst_wait_busy", busy, 0);
        chk("rst_wait_tx_ready", tx_ready, 1);
        chk("rst_wait_din", din, 0);
        tx_q.delete();
        n_done = n_starts;
        repeat (5) @(negedge clk);
        chk("rst_wait_no_restart", n_starts, n_done);

        // Watchdog on the TIMEOUT_LOG=4 instance: 16 WAIT cycles then err.
        b_push();
        repeat (17) @(negedge clk);
        chk("to_last_wait_busy", b_busy, 1);
        chk("to_last_wait_err", b_err, 0);
        @(negedge clk);
        chk("to_err_set", b_err, 1);
        chk("to_idle", b_busy, 0);
        chk("to_no_rx", b_rx_valid, 0);
        repeat (3) @(negedge clk);
        chk("to_err_sticky", b_err, 1);
        b_err_clr = 1'b1;
        @(negedge clk);
        b_err_clr = 1'b0;
        chk("to_err_cleared", b_err, 0);

        b_push();
        repeat (17) @(negedge clk);
        v            = 16'($urandom);
        b_spi_finish = 1'b1;
        b_dout       = v;
        @(negedge clk);
        b_spi_finish = 1'b0;
        chk("to_edge_finish_push", b_rx_valid, 1);
        chk("to_edge_finish_data", b_rx_data, v);
        chk("to_edge_finish_err", b_err, 0);
        chk("to_edge_finish_idle", b_busy, 0);
        b_rx_ready = 1'b1;
        @(negedge clk);
        b_rx_ready = 1'b0;
        chk("to_rx_drained", b_rx_valid, 0);

        b_push();
        repeat (17) @(negedge clk);
        b_err_clr = 1'b1;
        @(negedge clk);
        b_err_clr = 1'b0;
        chk("to_set_beats_clr", b_err, 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
